pipeline_hazard_ctl: RTL and testbench
======================================

// Module: pipeline_hazard_ctl
// PURPOSE
//  Sequencer for the rv32i in-order pipeline. Sits between the decoder and execute.
//  Tracks in-flight register writes in a scoreboard.
//  Generates stall, flush and issue controls for IF/ID/EX.
//  Holds the pipeline on data hazards, branch/jump redirects and memory-busy cycles.
// PARAMETERS
//  DEPTH    3   scoreboard entries = stages after ID holding an uncommitted rd (EX, MEM, WB)
//  CNT_W    16  width of the saturating stall-cycle counter
// PORTS
//  clk          in   1      clock; all state on posedge
//  rst          in   1      reset: asynchronous and active-high
//  id_valid     in   1      ID holds a decoded instruction
//  id_rs1       in   5      source reg 1 of ID instruction
//  id_rs2       in   5      source reg 2 of ID instruction
//  id_use_rs1   in   1      ID instruction reads rs1
//  id_use_rs2   in   1      ID instruction reads rs2
//  id_rd        in   5      destination reg of ID instruction
//  id_reg_we    in   1      ID instruction writes rd
//  id_is_load   in   1      ID instruction is a load
//  ex_redirect  in   1      EX resolved taken branch/JAL/JALR this cycle (held high by EX while mem_busy)
//  mem_busy     in   1      memory stage cannot advance
//  stall_if     out  1      hold PC/IF register
//  stall_id     out  1      hold ID register
//  flush_id     out  1      invalidate ID register at next edge
//  issue        out  1      ID instruction moves to EX at next edge
//  ex_valid     out  1      registered: EX holds a real (non-bubble) instruction
//  stall_cnt    out  CNT_W  cycles with stall_id=1 and flush_id=0, saturating
// BEHAVIOUR
//  Reset: scoreboard cleared (all valid=0), FSM=RUN, ex_valid=0, stall_cnt=0.
//   Combinational outputs evaluate to 0 while scoreboard empty and FSM=RUN.
//  Scoreboard entry = {valid, rd, is_load}; entry0 = EX ... entry DEPTH-1 = WB.
//  Advance: when !mem_busy, entries shift up by one and entry DEPTH-1 retires.
//   entry0 <= {issue & id_reg_we & (id_rd!=0), id_rd, id_is_load}, else bubble.
//  Match: id_use_rsN & (id_rsN!=0) & entry.valid & entry.rd==id_rsN.
//  hazard (no FORWARD_EN): match against any entry 0..DEPTH-1.
//  FSM RUN (default):
//   mem_busy: stall_if=stall_id=1, no shift, issue=0, ex_valid held. mem_busy has top priority.
//   else ex_redirect: flush_id=1, issue=0, entry0<=bubble, go FLUSH. Redirect beats hazard.
//   else id_valid & hazard: stall_if=stall_id=1, issue=0, entry0<=bubble.
//   else issue=id_valid.
//  FSM FLUSH, 1 cycle; the wrong-path instruction now in ID is discarded:
//   flush_id=1, issue=0, entry0<=bubble, return RUN.
//   mem_busy in FLUSH: stay in FLUSH, hold flush_id=1.
//   ex_redirect in FLUSH: ignored, since EX holds a bubble.
//  Redirect penalty is exactly 2 bubbles.
//  ex_valid <= issue on every edge with !mem_busy.
//  stall_cnt: +1 per cycle with stall_id & !flush_id; stops at 2^CNT_W-1, no wrap.
//  rst asserted mid-stall or mid-flush: immediate return to reset state; in-flight entries dropped.
// CONFIGURATION
//  FORWARD_EN defined: EX/MEM/WB results are bypassed.
//   hazard = match on entry0 with entry0.is_load only (load-use), giving 1 bubble.
//  FORWARD_EN undefined: hazard as above (any entry).
//   A dependent instruction stalls until the producer retires from WB.
// STRUCTURE
//  Package rv32i_pipe_pkg: sb_entry_t struct {valid, rd[4:0], is_load}; hz_state_t enum {RUN, FLUSH}.
//  Register-index width constant REG_W=5 also lives in rv32i_pipe_pkg.
//  Sub-module hazard_scoreboard: shift register plus rs1/rs2 match vectors.
//   pipeline_hazard_ctl holds the FSM, the output priority logic and stall_cnt.
// TESTING
//  1. rst pulse mid-stream: all outputs 0, stall_cnt=0, then the next independent instr issues.
//  2. ADD x5 then ADD x6,x5,x1, no FORWARD_EN: stall_id=1 for 3 cycles, then issue=1.
//     Same sequence with FORWARD_EN: 0 stall cycles.
//  3. LW x7 then ADD x8,x7,x7 with FORWARD_EN: exactly 1 stall cycle.
//     ex_valid=0 for that bubble; stall_cnt=1.
//  4. ex_redirect=1 for 1 cycle: flush_id=1 for 2 cycles, issue=0 both, state back to RUN.
//  5. mem_busy=1 for 4 cycles during a load-use stall: no shift; stall_cnt+=4.
//     The stall resolves 1 cycle after mem_busy drops.
//  6. stall_cnt preset near 0xFFFF via sustained stalls: holds at 0xFFFF, no wrap.
//     Also: x0 as source/dest never causes a stall.

Source files
------------

// File: rtl/rv32i_pipe_pkg.sv
// rv32i_pipe_pkg
//   Shared types and constants for the rv32i in-order pipeline hazard control.
//   - REG_W      : register-index width
//   - FORWARD    : 1 when the FORWARD_EN macro is defined (EX/MEM/WB bypass
//                  present, only load-use needs a bubble), 0 otherwise
//   - sb_entry_t : one scoreboard slot {valid, rd, is_load}
//   - hz_state_t : sequencer state {RUN, FLUSH}
// Configuration macro: FORWARD_EN
package rv32i_pipe_pkg;

   localparam int REG_W = 5;

`ifdef FORWARD_EN
   localparam bit FORWARD = 1'b1;
`else
   localparam bit FORWARD = 1'b0;
`endif

   typedef struct packed {
      logic             valid;
      logic [REG_W-1:0] rd;
      logic             is_load;
   } sb_entry_t;

   typedef enum logic {
      RUN   = 1'b0,
      FLUSH = 1'b1
   } hz_state_t;

endpackage

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard
//   Shift register of uncommitted destination registers, one slot per stage
//   after ID (slot 0 = EX ... slot DEPTH-1 = WB), plus per-slot source-match
//   vectors for the instruction currently in ID.
//   Ports:
//     clk, rst        clock, asynchronous active-high reset
//     advance         pipeline moves this cycle: shift and load slot 0
//     push_valid      slot 0 receives a real register writer
//     push_rd         destination register of the entering instruction
//     push_load       entering instruction is a load
//     rs1, rs2        ID source registers
//     use_rs1,use_rs2 ID instruction reads the corresponding source
//     rs1_hit,rs2_hit per-slot hazard hits (already filtered for forwarding)
// Configuration macro: FORWARD_EN (via rv32i_pipe_pkg::FORWARD)
module hazard_scoreboard
   import rv32i_pipe_pkg::*;
#(
   parameter int DEPTH = 3
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             advance,
   input  logic             push_valid,
   input  logic [4:0]       push_rd,
   input  logic             push_load,
   input  logic [4:0]       rs1,
   input  logic [4:0]       rs2,
   input  logic             use_rs1,
   input  logic             use_rs2,
   output logic [DEPTH-1:0] rs1_hit,
   output logic [DEPTH-1:0] rs2_hit
);

   sb_entry_t [DEPTH-1:0] sb;
   logic                  slot_en;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sb <= '0;
      end else if (advance) begin
         for (int i = 1; i < DEPTH; i++) begin
            sb[i] <= sb[i-1];
         end
         sb[0].valid   <= push_valid;
         sb[0].rd      <= push_rd;
         sb[0].is_load <= push_load;
      end
   end

   // With bypassing, only a load sitting in EX cannot supply its result in
   // time; every other producer is forwarded and never blocks ID.
   always_comb begin
      rs1_hit = '0;
      rs2_hit = '0;
      slot_en = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         slot_en    = sb[i].valid & (FORWARD ? ((i == 0) & sb[i].is_load) : 1'b1);
         rs1_hit[i] = slot_en & use_rs1 & (rs1 != 5'd0) & (sb[i].rd == rs1);
         rs2_hit[i] = slot_en & use_rs2 & (rs2 != 5'd0) & (sb[i].rd == rs2);
      end
   end

endmodule

// File: rtl/pipeline_hazard_ctl.sv
// pipeline_hazard_ctl
//   Sequencer between decode and execute of the rv32i in-order pipeline.
//   Generates stall/flush/issue controls from data hazards, branch/jump
//   redirects and memory-busy cycles, and counts stall cycles.
//   Ports:
//     clk, rst             clock, asynchronous active-high reset
//     id_valid             ID holds a decoded instruction
//     id_rs1, id_rs2       ID source registers
//     id_use_rs1/rs2       ID instruction reads that source
//     id_rd, id_reg_we     ID destination register and write enable
//     id_is_load           ID instruction is a load
//     ex_redirect          EX resolved a taken branch/jump (held while mem_busy)
//     mem_busy             memory stage cannot advance
//     stall_if, stall_id   hold PC/IF and ID registers
//     flush_id             invalidate ID register at next edge
//     issue                ID instruction enters EX at next edge
//     ex_valid             EX holds a real instruction (registered)
//     stall_cnt            saturating count of cycles with stall_id & !flush_id
//   Priority: mem_busy > redirect > data hazard > issue.
//   A redirect costs two bubbles: the redirect cycle and one FLUSH cycle that
//   discards the wrong-path instruction that reached ID meanwhile.
// Configuration macro: FORWARD_EN (load-use only hazards when defined)
module pipeline_hazard_ctl
   import rv32i_pipe_pkg::*;
#(
   parameter int DEPTH = 3,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             id_valid,
   input  logic [4:0]       id_rs1,
   input  logic [4:0]       id_rs2,
   input  logic             id_use_rs1,
   input  logic             id_use_rs2,
   input  logic [4:0]       id_rd,
   input  logic             id_reg_we,
   input  logic             id_is_load,
   input  logic             ex_redirect,
   input  logic             mem_busy,
   output logic             stall_if,
   output logic             stall_id,
   output logic             flush_id,
   output logic             issue,
   output logic             ex_valid,
   output logic [CNT_W-1:0] stall_cnt
);

   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   hz_state_t        state;
   hz_state_t        state_nxt;
   logic [DEPTH-1:0] rs1_hit;
   logic [DEPTH-1:0] rs2_hit;
   logic             hazard;
   logic             push_valid;

   // A write to x0 is architecturally void, so it never enters the scoreboard.
   assign push_valid = issue & id_reg_we & (id_rd != 5'd0);
   assign hazard     = |(rs1_hit | rs2_hit);

   hazard_scoreboard #(
      .DEPTH (DEPTH)
   ) u_sb (
      .clk        (clk),
      .rst        (rst),
      .advance    (~mem_busy),
      .push_valid (push_valid),
      .push_rd    (id_rd),
      .push_load  (id_is_load),
      .rs1        (id_rs1),
      .rs2        (id_rs2),
      .use_rs1    (id_use_rs1),
      .use_rs2    (id_use_rs2),
      .rs1_hit    (rs1_hit),
      .rs2_hit    (rs2_hit)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= RUN;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      stall_if  = 1'b0;
      stall_id  = 1'b0;
      flush_id  = 1'b0;
      issue     = 1'b0;
      case (state)
         RUN: begin
            if (mem_busy) begin
               stall_if = 1'b1;
               stall_id = 1'b1;
            end else if (ex_redirect) begin
               flush_id  = 1'b1;
               state_nxt = FLUSH;
            end else if (id_valid & hazard) begin
               stall_if = 1'b1;
               stall_id = 1'b1;
            end else begin
               issue = id_valid;
            end
         end
         FLUSH: begin
            // EX holds a bubble here, so ex_redirect is meaningless and ignored.
            flush_id = 1'b1;
            if (mem_busy) begin
               stall_if = 1'b1;
               stall_id = 1'b1;
            end else begin
               state_nxt = RUN;
            end
         end
         default: state_nxt = RUN;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ex_valid  <= 1'b0;
         stall_cnt <= '0;
      end else begin
         if (!mem_busy) begin
            ex_valid <= issue;
         end
         if (stall_id & ~flush_id & (stall_cnt != {CNT_W{1'b1}})) begin
            stall_cnt <= stall_cnt + CNT_ONE;
         end
      end
   end

endmodule

// File: tb/tb_pipeline_hazard_ctl.sv
// tb_pipeline_hazard_ctl
//   Bench for pipeline_hazard_ctl: directed scenarios with hand-computed
//   expectations plus a randomized stream, all outputs compared every cycle
//   against a stage-occupancy model of the pipeline.
//   Honours the FORWARD_EN macro in the same way as the design.
module tb_pipeline_hazard_ctl;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        id_valid = 1'b0;
   logic [4:0]  id_rs1 = '0;
   logic [4:0]  id_rs2 = '0;
   logic        id_use_rs1 = 1'b0;
   logic        id_use_rs2 = 1'b0;
   logic [4:0]  id_rd = '0;
   logic        id_reg_we = 1'b0;
   logic        id_is_load = 1'b0;
   logic        ex_redirect = 1'b0;
   logic        mem_busy = 1'b0;
   logic        stall_if, stall_id, flush_id, issue, ex_valid;
   logic [15:0] stall_cnt;

   int n_tests = 0;
   int n_fail  = 0;

   pipeline_hazard_ctl #(.DEPTH(3), .CNT_W(16)) dut (
      .clk         (clk),
      .rst         (rst),
      .id_valid    (id_valid),
      .id_rs1      (id_rs1),
      .id_rs2      (id_rs2),
      .id_use_rs1  (id_use_rs1),
      .id_use_rs2  (id_use_rs2),
      .id_rd       (id_rd),
      .id_reg_we   (id_reg_we),
      .id_is_load  (id_is_load),
      .ex_redirect (ex_redirect),
      .mem_busy    (mem_busy),
      .stall_if    (stall_if),
      .stall_id    (stall_id),
      .flush_id    (flush_id),
      .issue       (issue),
      .ex_valid    (ex_valid),
      .stall_cnt   (stall_cnt)
   );

   // ---------------- clock ----------------
   always #5 clk = ~clk;

   initial begin
      #1500000;
      $display("FAIL watchdog: simulation time limit reached");
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
      $fatal(1, "watchdog");
   end

   task automatic check(string name, logic [31:0] act, logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   // Occupancy of EX, MEM, WB: which register each holds, uncommitted.
   bit m_busy_wr[3];
   int m_dest[3];
   bit m_load[3];
   bit m_in_flush;
   bit m_exv;
   int m_cnt;
   bit e_stall, e_flush, e_issue;

   function automatic bit reads_from(int k);
      bit h1, h2;
      h1 = id_use_rs1 && (id_rs1 != 0) && m_busy_wr[k] && (m_dest[k] == int'(id_rs1));
      h2 = id_use_rs2 && (id_rs2 != 0) && m_busy_wr[k] && (m_dest[k] == int'(id_rs2));
      return h1 || h2;
   endfunction

   function automatic bit must_wait();
`ifdef FORWARD_EN
      return reads_from(0) && m_load[0];
`else
      return reads_from(0) || reads_from(1) || reads_from(2);
`endif
   endfunction

   always @(negedge clk) begin
      if (rst) begin
         for (int k = 0; k < 3; k++) begin
            m_busy_wr[k] = 0; m_dest[k] = 0; m_load[k] = 0;
         end
         m_in_flush = 0;
         m_exv      = 0;
         m_cnt      = 0;
         check("rst_ex_valid", ex_valid, 0);
         check("rst_stall_cnt", stall_cnt, 0);
      end else begin
         e_stall = mem_busy;
         e_flush = 0;
         e_issue = 0;
         if (m_in_flush) e_flush = 1;
         else if (mem_busy) e_stall = 1;
         else if (ex_redirect) e_flush = 1;
         else if (id_valid && must_wait()) e_stall = 1;
         else e_issue = id_valid;

         check("stall_if", stall_if, e_stall);
         check("stall_id", stall_id, e_stall);
         check("flush_id", flush_id, e_flush);
         check("issue", issue, e_issue);
         check("ex_valid", ex_valid, m_exv);
         check("stall_cnt", stall_cnt, m_cnt);

         if (!mem_busy) begin
            for (int k = 2; k > 0; k--) begin
               m_busy_wr[k] = m_busy_wr[k-1]; m_dest[k] = m_dest[k-1]; m_load[k] = m_load[k-1];
            end
            m_busy_wr[0] = e_issue && id_reg_we && (id_rd != 0);
            m_dest[0]    = int'(id_rd);
            m_load[0]    = id_is_load;
            m_exv        = e_issue;
         end
         if (e_stall && !e_flush && m_cnt < 65535) m_cnt++;
         m_in_flush = m_in_flush ? mem_busy : (!mem_busy && ex_redirect);
      end
   end

   // ---------------- driver tasks ----------------
   task automatic cyc(bit v, int r1, int r2, bit u1, bit u2, int rd, bit we, bit ld,
                      bit redir, bit busy);
      @(posedge clk);
      #1;
      id_valid    = v;
      id_rs1      = r1[4:0];
      id_rs2      = r2[4:0];
      id_use_rs1  = u1;
      id_use_rs2  = u2;
      id_rd       = rd[4:0];
      id_reg_we   = we;
      id_is_load  = ld;
      ex_redirect = redir;
      mem_busy    = busy;
      @(negedge clk);
      #1;
   endtask

   task automatic do_reset();
      @(posedge clk);
      #2;
      rst         = 1'b1;
      id_valid    = 0; id_rs1 = 0; id_rs2 = 0; id_use_rs1 = 0; id_use_rs2 = 0;
      id_rd       = 0; id_reg_we = 0; id_is_load = 0; ex_redirect = 0; mem_busy = 0;
      #1;
      check("reset_stall_if", stall_if, 0);
      check("reset_stall_id", stall_id, 0);
      check("reset_flush_id", flush_id, 0);
      check("reset_issue", issue, 0);
      @(negedge clk);
      #1;
      rst = 1'b0;
   endtask

   // Present one instruction in ID until it issues; report stall cycles seen
   // and whether EX held a real instruction in the issue cycle.
   task automatic issue_instr(int r1, int r2, int rd, bit ld, output int stalls,
                              output bit exv_at_issue);
      bit done;
      done = 0;
      stalls = 0;
      exv_at_issue = 0;
      for (int k = 0; k < 20 && !done; k++) begin
         cyc(1, r1, r2, 1, 1, rd, 1, ld, 0, 0);
         if (issue) begin
            done = 1;
            exv_at_issue = ex_valid;
         end else if (stall_id) begin
            stalls++;
         end
      end
      if (!done) begin
         n_tests++;
         n_fail++;
         $display("FAIL issue_timeout: rd=%0d never issued within 20 cycles", rd);
      end
   endtask

   // ---------------- stimulus ----------------
   int  st;
   bit  ev;
   int  exp_stalls;
   bit  held_redir;
   bit  busy_r, redir_r;

   initial begin
`ifdef FORWARD_EN
      exp_stalls = 0;
`else
      exp_stalls = 3;
`endif
      repeat (2) @(posedge clk);
      #2;
      rst = 1'b0;

      // Reset mid-stream drops the in-flight x5 writer.
      do_reset();
      issue_instr(1, 2, 5, 0, st, ev);
      do_reset();
      issue_instr(5, 1, 6, 0, st, ev);
      check("t1_stalls_after_reset", st, 0);

      // ADD x5 ; ADD x6,x5,x1
      do_reset();
      issue_instr(1, 2, 5, 0, st, ev);
      issue_instr(5, 1, 6, 0, st, ev);
      check("t2_raw_stalls", st, exp_stalls);
      check("t2_stall_cnt", stall_cnt, exp_stalls);
      check("t2_ex_valid", ev, (exp_stalls == 0));

      // LW x7 ; ADD x8,x7,x7
`ifdef FORWARD_EN
      exp_stalls = 1;
`else
      exp_stalls = 3;
`endif
      do_reset();
      issue_instr(1, 2, 7, 1, st, ev);
      issue_instr(7, 7, 8, 0, st, ev);
      check("t3_load_use_stalls", st, exp_stalls);
      check("t3_stall_cnt", stall_cnt, exp_stalls);
      check("t3_bubble_ex_valid", ev, 0);

      // One-cycle redirect: two flush cycles, then issue resumes.
      do_reset();
      cyc(1, 3, 4, 1, 1, 9, 1, 0, 1, 0);
      check("t4_flush_c0", flush_id, 1);
      check("t4_issue_c0", issue, 0);
      cyc(1, 3, 4, 1, 1, 9, 1, 0, 0, 0);
      check("t4_flush_c1", flush_id, 1);
      check("t4_issue_c1", issue, 0);
      cyc(1, 3, 4, 1, 1, 9, 1, 0, 0, 0);
      check("t4_flush_c2", flush_id, 0);
      check("t4_issue_c2", issue, 1);
      check("t4_ex_valid_c2", ex_valid, 0);
      cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

      // mem_busy for 4 cycles on top of a load-use stall.
      do_reset();
      issue_instr(1, 2, 7, 1, st, ev);
      for (int k = 0; k < 4; k++) begin
         cyc(1, 7, 7, 1, 1, 8, 1, 0, 0, 1);
         check("t5_busy_stall", stall_id, 1);
         check("t5_busy_issue", issue, 0);
      end
      issue_instr(7, 7, 8, 0, st, ev);
      check("t5_stalls_after_busy", st, exp_stalls);
      check("t5_stall_cnt", stall_cnt, 4 + exp_stalls);

      // x0 never creates a dependency.
      do_reset();
      issue_instr(1, 2, 0, 1, st, ev);
      issue_instr(0, 0, 4, 0, st, ev);
      check("t6_x0_stalls", st, 0);

      // Saturation of the stall counter.
      do_reset();
      repeat (65535) cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
      check("t7_cnt_fffe", stall_cnt, 16'hFFFE);
      cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
      check("t7_cnt_ffff", stall_cnt, 16'hFFFF);
      repeat (3) cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
      check("t7_cnt_hold", stall_cnt, 16'hFFFF);

      // Randomized stream with small register range to provoke hazards.
      do_reset();
      held_redir = 0;
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 299) == 0) begin
            do_reset();
            held_redir = 0;
         end else begin
            busy_r     = ($urandom_range(0, 3) == 0);
            redir_r    = held_redir ? 1'b1 : ($urandom_range(0, 9) == 0);
            held_redir = redir_r && busy_r;
            cyc($urandom_range(0, 3) != 0, $urandom_range(0, 7), $urandom_range(0, 7),
                $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 7),
                $urandom_range(0, 1), $urandom_range(0, 1), redir_r, busy_r);
         end
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
